input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage that sits directly upstream of the calculator/ID-roller core. It takes the raw, bouncing push-buttons and slide switches from the board, synchronises them into the `clock` domain, debounces them, and produces the clean level signals the core consumes: `P` and `M` as press-to-toggle mode bits, `equal` as a debounced level, and `num1` as a debounced 4-bit operand. It also emits one-cycle press pulses for any later consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new input level (10 ms at 100 MHz). Legal range is 2 to 2^24−1.
- `CNT_W`, default 24: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_p` in 1: raw ID-select button, asynchronous to `clock`.
- `btn_m` in 1: raw mode button, asynchronous to `clock`.
- `btn_equal` in 1: raw equals button, asynchronous to `clock`.
- `sw` in 4: raw operand switches, asynchronous to `clock`.
- `P` out 1: ID-select toggle. 0 selects ID1, 1 selects ID2.
- `M` out 1: mode toggle. 0 is roll mode, 1 is calculator mode.
- `equal` out 1: debounced level of `btn_equal`.
- `num1` out 4: debounced switch value, two's complement.
- `p_press` out 1: one-cycle pulse on each accepted press of `btn_p`.
- `m_press` out 1: one-cycle pulse on each accepted press of `btn_m`.
- `eq_press` out 1: one-cycle pulse on each accepted press of `btn_equal`.

## Operation
- **Synchroniser:** each raw input passes through a 2-flop synchroniser. `sw` uses 4 parallel 2-flop chains. All synchroniser flops reset to 0.
- **Button channels** (three identical instances, for P, M and equal):
  - Each channel holds the accepted level `q`, a counter `cnt[CNT_W-1:0]`, and the synchronised sample `s`.
  - If `s == q`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `q <= s` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - A bounce that returns to `q` before the count completes clears `cnt`; no partial credit is kept.
  - Press pulse is `q & ~q_d`, where `q_d` is `q` delayed by one cycle. It is registered, so the pulse is high exactly one cycle.
  - A release never pulses.
- **Toggles:**
  - `P <= P ^ p_press_internal`.
  - `M <= M ^ m_press_internal`.
  - `P` and `M` change on the same edge their pulse is asserted.
  - `equal` is the accepted `q` of the equal channel, not a toggle.
- **Switch channel (bus-coherent):**
  - Holds the accepted value `num1`, the previous synchronised sample `sp`, and a counter.
  - If `s == num1`: `cnt <= 0`.
  - Else if `s != sp`: `cnt <= 0`, because the bus is still moving.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `num1 <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - `num1` never shows an intermediate value unless that value itself was held stable.
- **Simultaneous events:** channels are fully independent. Presses of P, M and equal accepted on the same edge all pulse and toggle together.
- **Held button:** yields exactly one press pulse and one toggle, no matter how long it is held.
- **Reset mid-operation:** asynchronously clears every counter, `q`, `q_d`, toggle and output. A button held through reset release is treated as a new press after the debounce interval.

## Timing
- **Reset values:** `P`, `M`, `equal`, `num1`, `p_press`, `m_press` and `eq_press` are all 0.
- **Button latency:** with edge 0 being the edge where sync stage 1 first captures the new raw level:
  - `q` (and therefore `equal`) changes at edge `DEBOUNCE_CYCLES+2`.
  - The press pulse and the toggle of `P`/`M` occur at edge `DEBOUNCE_CYCLES+3`.
- **Switch latency:** `num1` updates at edge `DEBOUNCE_CYCLES+2` after the last bus transition is captured.
- **Glitch rejection:** a raw glitch lasting fewer than `DEBOUNCE_CYCLES` cycles produces no output change.
- **Pulse width:** exactly 1 cycle. The minimum spacing between two pulses on the same channel is `2*DEBOUNCE_CYCLES+…` cycles, i.e. one press-release-press cycle.
- **Counter wrap:** the counter never wraps, because it is cleared at terminal count.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.

1. **Reset:** assert `reset_n=0` mid-count with `btn_m=1` for 3 cycles → all outputs 0 immediately. After release and 6 stable cycles, `m_press` pulses once and `M=1`.
2. **Clean press:** `btn_p` goes 0→1 and stays high → `p_press` is high for exactly 1 cycle at edge 7 and `P` becomes 1. A second press-release pair returns `P` to 0.
3. **Bounce rejection:** `btn_equal` toggles 1,0,1,0,1 at 2-cycle intervals, then holds 1 → `equal` rises only 6 edges after the final rising sample. `eq_press` pulses exactly once.
4. **Switch settling:** `sw` steps 0011→0111→0110 at 2-cycle spacing, then holds → `num1` goes directly 0000→0110 and never shows 0011 or 0111.
5. **Simultaneous:** `btn_p` and `btn_m` rise on the same cycle → `p_press` and `m_press` both pulse on the same edge, and `P=1`, `M=1`.
6. **Held button:** `btn_m` held high for 200 cycles → one `m_press` pulse only, and `M` stays 1 throughout.

Source files
------------

// File: rtl/input_conditioner.sv
// Board input front end: synchronises, debounces and conditions the raw
// push-buttons and operand switches into clean levels, toggles and pulses.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 24
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_p,
    input  logic       btn_m,
    input  logic       btn_equal,
    input  logic [3:0] sw,
    output logic       P,
    output logic       M,
    output logic       equal,
    output logic [3:0] num1,
    output logic       p_press,
    output logic       m_press,
    output logic       eq_press
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button lanes: bit 0 = P, bit 1 = M, bit 2 = equal
    logic [2:0]       btn;
    logic [2:0]       b_s1;
    logic [2:0]       b_s2;
    logic [2:0]       b_smp;
    logic [2:0]       b_q;
    logic [2:0]       b_qd;
    logic [2:0]       press;
    logic [2:0]       rise;
    logic [CNT_W-1:0] b_cnt [3];

    logic [3:0]       sw_s1;
    logic [3:0]       sw_s2;
    logic [3:0]       sw_sp;
    logic [CNT_W-1:0] sw_cnt;

    assign btn  = {btn_equal, btn_m, btn_p};
    assign rise = b_q & ~b_qd;

    assign p_press  = press[0];
    assign m_press  = press[1];
    assign eq_press = press[2];
    assign equal    = b_q[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            b_s1  <= '0;
            b_s2  <= '0;
            b_smp <= '0;
            b_q   <= '0;
            b_qd  <= '0;
            press <= '0;
            P     <= 1'b0;
            M     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                b_cnt[i] <= '0;
            end
        end else begin
            b_s1  <= btn;
            b_s2  <= b_s1;
            b_smp <= b_s2;
            b_qd  <= b_q;
            press <= rise;
            // Toggle on the same edge the registered pulse goes high
            P     <= P ^ rise[0];
            M     <= M ^ rise[1];
            for (int i = 0; i < 3; i++) begin
                if (b_smp[i] == b_q[i]) begin
                    b_cnt[i] <= '0;
                end else if (b_cnt[i] == TERM) begin
                    b_q[i]   <= b_smp[i];
                    b_cnt[i] <= '0;
                end else begin
                    b_cnt[i] <= b_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Whole-bus settling: any bit still moving restarts the count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            sw_sp  <= '0;
            sw_cnt <= '0;
            num1   <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            sw_sp <= sw_s2;
            if (sw_s2 == num1) begin
                sw_cnt <= '0;
            end else if (sw_s2 != sw_sp) begin
                sw_cnt <= '0;
            end else if (sw_cnt == TERM) begin
                num1   <= sw_s2;
                sw_cnt <= '0;
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a short debounce interval.
// Expected press events are queued at stimulus time and matched on output.
module tb_input_conditioner;

    localparam int D = 4;

    logic       clock;
    logic       reset_n;
    logic       btn_p;
    logic       btn_m;
    logic       btn_equal;
    logic [3:0] sw;
    logic       P;
    logic       M;
    logic       equal;
    logic [3:0] num1;
    logic       p_press;
    logic       m_press;
    logic       eq_press;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_p    (btn_p),
        .btn_m    (btn_m),
        .btn_equal(btn_equal),
        .sw       (sw),
        .P        (P),
        .M        (M),
        .equal    (equal),
        .num1     (num1),
        .p_press  (p_press),
        .m_press  (m_press),
        .eq_press (eq_press)
    );

    typedef struct {
        int         cyc;
        logic [2:0] pulses;
        logic       p;
        logic       m;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         eq_rise_cyc;
    int         n1_first_cyc;
    logic [3:0] n1_first_val;
    int         n1_changes;
    logic [3:0] prev_n1;
    logic       prev_eq;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Edge 0 of a change driven now is the next posedge, index cyc+1
    function automatic void expect_press(input logic [2:0] pl,
                                         input logic p,
                                         input logic m);
        exp_t e;
        e.cyc    = cyc + 1 + D + 3;
        e.pulses = pl;
        e.p      = p;
        e.m      = m;
        exp_q.push_back(e);
    endfunction

    task automatic run_window(input int n);
        logic [2:0] pl;
        logic       pp;
        logic       pm;
        exp_t       e;
        pp = P;
        pm = M;
        repeat (n) begin
            @(negedge clock);
            pl = {eq_press, m_press, p_press};
            if (equal && !prev_eq && eq_rise_cyc < 0) eq_rise_cyc = cyc;
            prev_eq = equal;
            if (num1 !== prev_n1) begin
                if (n1_changes == 0) begin
                    n1_first_cyc = cyc;
                    n1_first_val = num1;
                end
                n1_changes++;
            end
            prev_n1 = num1;
            checks++;
            if (pl != 3'b000) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%b want=000",
                             cyc, pl);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || pl !== e.pulses ||
                        P !== e.p || M !== e.m) begin
                        failures++;
                        $display("FAIL press_event got cyc=%0d pl=%b P=%b M=%b want cyc=%0d pl=%b P=%b M=%b",
                                 cyc, pl, P, M, e.cyc, e.pulses, e.p, e.m);
                    end
                end
            end else if (P !== pp || M !== pm) begin
                failures++;
                $display("FAIL toggle_no_pulse cyc=%0d got P=%b M=%b want P=%b M=%b",
                         cyc, P, M, pp, pm);
            end
            pp = P;
            pm = M;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulse got pending=%0d want 0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({P, M, equal, num1, p_press, m_press, eq_press} !== 10'b0) begin
            failures++;
            $display("FAIL %s got P=%b M=%b eq=%b num1=%h pp=%b mp=%b ep=%b want all 0",
                     tag, P, M, equal, num1, p_press, m_press, eq_press);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_p     = 1'b0;
        btn_m     = 1'b0;
        btn_equal = 1'b0;
        sw        = 4'h0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        prev_n1 = num1;
        prev_eq = equal;
        run_window(12);
    endtask

    task automatic test_clean_press();
        btn_p = 1'b1;
        expect_press(3'b001, 1'b1, 1'b0);
        run_window(12);
        checks++;
        if (P !== 1'b1) begin
            failures++;
            $display("FAIL first_press_P got=%b want=1", P);
        end
        btn_p = 1'b0;
        run_window(10);
        btn_p = 1'b1;
        expect_press(3'b001, 1'b0, 1'b0);
        run_window(12);
        btn_p = 1'b0;
        run_window(10);
        checks++;
        if (P !== 1'b0) begin
            failures++;
            $display("FAIL second_press_P got=%b want=0", P);
        end
    endtask

    task automatic test_bounce();
        int fin;
        for (int i = 0; i < 4; i++) begin
            btn_equal = (i % 2 == 0);
            run_window(2);
        end
        eq_rise_cyc = -1;
        btn_equal   = 1'b1;
        fin         = cyc + 1 + D + 2;
        expect_press(3'b100, P, M);
        run_window(12);
        checks++;
        if (eq_rise_cyc !== fin) begin
            failures++;
            $display("FAIL equal_rise got=%0d want=%0d", eq_rise_cyc, fin);
        end
        btn_equal = 1'b0;
        run_window(10);
        checks++;
        if (equal !== 1'b0) begin
            failures++;
            $display("FAIL equal_release got=%b want=0", equal);
        end
    endtask

    task automatic test_switch();
        int want_cyc;
        n1_changes = 0;
        sw = 4'b0011;
        run_window(2);
        sw = 4'b0111;
        run_window(2);
        sw = 4'b0110;
        want_cyc = cyc + 1 + D + 2;
        run_window(12);
        checks++;
        if (n1_changes !== 1 || n1_first_val !== 4'b0110 ||
            n1_first_cyc !== want_cyc) begin
            failures++;
            $display("FAIL switch_settle got n=%0d val=%b cyc=%0d want n=1 val=0110 cyc=%0d",
                     n1_changes, n1_first_val, n1_first_cyc, want_cyc);
        end
    endtask

    task automatic test_simultaneous();
        btn_p = 1'b1;
        btn_m = 1'b1;
        expect_press(3'b011, 1'b1, 1'b1);
        run_window(12);
        btn_p = 1'b0;
        btn_m = 1'b0;
        run_window(10);
        checks++;
        if (P !== 1'b1 || M !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous_levels got P=%b M=%b want 1 1", P, M);
        end
    endtask

    task automatic test_reset_mid();
        btn_m = 1'b1;
        run_window(3);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(negedge clock);
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        expect_press(3'b010, 1'b0, 1'b1);
        run_window(12);
    endtask

    task automatic test_held();
        run_window(200);
        checks++;
        if (M !== 1'b1) begin
            failures++;
            $display("FAIL held_M got=%b want=1", M);
        end
        btn_m = 1'b0;
        run_window(10);
        checks++;
        if (M !== 1'b1) begin
            failures++;
            $display("FAIL release_M got=%b want=1", M);
        end
    endtask

    initial begin
        eq_rise_cyc  = -1;
        n1_changes   = 0;
        n1_first_cyc = -1;
        n1_first_val = 4'h0;
        prev_n1      = 4'h0;
        prev_eq      = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_switch();
        test_simultaneous();
        test_reset_mid();
        test_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
